mux8_rr_sched: RTL and testbench

Round-robin scheduler that shares one `mux8_mux2` 8:1 datapath mux between eight requesters. It arbitrates `req[7:0]`, issues a one-hot registered grant, and drives the mux `sel[2:0]` so that the granted requester's bit is routed to the mux output. Each tenure is bounded to `MAX_HOLD` cycles, so no requester can starve the others.

---
 rtl/mux8_rr_sched.sv | 177 +++++++++++++++++
 tb/tb_mux8_rr_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched -- round-robin scheduler for one shared 8:1 datapath mux.
//
// Arbitrates eight level-sensitive requests and issues a registered one-hot
// grant together with the matching mux select. A tenure lasts at most
// MAX_HOLD cycles. On release the scheduler hands over to the next requester
// on the same edge, so there is neither an overlap nor a gap.
//
// Optional feature: define MUX8_SCHED_PRIO0_EN to give requester 0 absolute
// priority in every arbitration. Requester 0's tenures are then exempt from
// MAX_HOLD, and grants to it leave the round-robin pointer untouched.
// Requests never preempt a running tenure, with or without the macro.

module mux8_rr_sched #(
  parameter int MAX_HOLD = 4  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic [2:0] owner
);

  localparam int              HW         = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   MAX_HOLD_C = HW'(MAX_HOLD);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state_q,  state_d;
  logic [7:0]      gnt_q,    gnt_d;
  logic [2:0]      sel_q,    sel_d;
  logic            valid_q,  valid_d;
  logic [2:0]      owner_q,  owner_d;
  logic [2:0]      ptr_q,    ptr_d;
  logic [HW-1:0]   hold_q,   hold_d;

  logic            do_grant;
  logic [7:0]      arb_vec;
  logic [2:0]      arb_start;
  logic [2:0]      winner;
  logic [7:0]      masked_req;
  logic            owner_exempt;
  logic            release_now;

  // Scan ptr, ptr+1, ... ptr+7 (mod 8) and return the first requesting index.
  function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                         input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = start;
    found = 1'b0;
`ifdef MUX8_SCHED_PRIO0_EN
    if (r[0]) begin
      pick  = 3'd0;
      found = 1'b1;
    end
`endif
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign masked_req = req & ~(8'b1 << owner_q);

`ifdef MUX8_SCHED_PRIO0_EN
  assign owner_exempt = (owner_q == 3'd0);
`else
  assign owner_exempt = 1'b0;
`endif

  assign release_now = !req[owner_q] || (!owner_exempt && (hold_q == MAX_HOLD_C));

  // Next-state logic: decide between hold, handover, re-grant and going idle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in combinational logic would infer a latch).
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    do_grant  = 1'b0;
    arb_vec   = req;
    arb_start = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (req != 8'h00) begin
          do_grant = 1'b1;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          if (masked_req != 8'h00) begin
            // Back-to-back handover, scanning from just past the old owner.
            do_grant  = 1'b1;
            arb_vec   = masked_req;
            arb_start = owner_q + 3'd1;
          end else if (req[owner_q]) begin
            // Timeout with no competitor: same owner starts a fresh tenure.
            hold_d = HW'(1);
            ptr_d  = owner_q + 3'd1;
          end else begin
            // Nobody left: sel and owner keep their last value.
            state_d = S_IDLE;
            gnt_d   = 8'h00;
            valid_d = 1'b0;
          end
        end else if (hold_q != MAX_HOLD_C) begin
          // Saturating, so an exempt tenure cannot wrap the counter.
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    winner = rr_pick(arb_vec, arb_start);

    if (do_grant) begin
      state_d = S_GRANT;
      gnt_d   = 8'b1 << winner;
      sel_d   = winner;
      owner_d = winner;
      valid_d = 1'b1;
      hold_d  = HW'(1);
      ptr_d   = winner + 3'd1;
`ifdef MUX8_SCHED_PRIO0_EN
      if (winner == 3'd0) begin
        ptr_d = ptr_q;
      end
`endif
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      owner_q <= 3'd0;
      ptr_q   <= 3'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Testbench for mux8_rr_sched: directed phases from the scheduler's intended
// behaviour followed by randomized request traffic. A reference model computes
// each cycle's expected outputs into a queue, and a monitor compares them.

module tb_mux8_rr_sched;

  localparam int MAX_HOLD = 4;
`ifdef MUX8_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic [2:0] owner;
  } out_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic [2:0] owner;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  out_t        exp_q[$];

  mux8_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .owner (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Tenure-level view: who owns the mux (-1 = nobody), how many cycles the
  // current tenure has run, the round-robin start point, and the last grantee.
  int m_owner = -1;
  int m_len   = 0;
  int m_ptr   = 0;
  int m_last  = 0;

  function automatic int pick(input logic [7:0] r, input int p);
    if (PRIO0 && r[0]) return 0;
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic start_tenure(input int w);
    m_owner = w;
    m_last  = w;
    m_len   = 1;
    if (!(PRIO0 && w == 0)) m_ptr = (w + 1) % 8;
  endtask

  task automatic model_step(input logic r_rst, input logic [7:0] r);
    int         o;
    bit         exempt;
    logic [7:0] masked;
    if (r_rst) begin
      m_owner = -1;
      m_len   = 0;
      m_ptr   = 0;
      m_last  = 0;
    end else if (m_owner < 0) begin
      if (r != 8'h00) start_tenure(pick(r, m_ptr));
    end else begin
      o      = m_owner;
      exempt = PRIO0 && (o == 0);
      if (!r[o] || (!exempt && m_len >= MAX_HOLD)) begin
        masked    = r;
        masked[o] = 1'b0;
        if (masked != 8'h00) begin
          start_tenure(pick(masked, (o + 1) % 8));
        end else if (r[o]) begin
          m_len = 1;
          m_ptr = (o + 1) % 8;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_len++;
      end
    end
  endtask

  function automatic out_t model_out();
    out_t e;
    e.gnt   = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
    e.valid = (m_owner >= 0);
    e.sel   = 3'(m_last);
    e.owner = 3'(m_last);
    return e;
  endfunction

  // Model advances on the same edge as the DUT and queues the expectation.
  always @(posedge clk) begin
    model_step(rst, req);
    exp_q.push_back(model_out());
  end

  // Monitor: just after each edge, compare DUT outputs with the oldest expectation.
  always begin
    out_t act;
    out_t e;
    @(posedge clk);
    #1;
    act = '{gnt: gnt, sel: sel, valid: valid, owner: owner};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty t=%0t actual gnt=%h sel=%0d valid=%b owner=%0d, no expectation queued",
               $time, act.gnt, act.sel, act.valid, act.owner);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        miscompares++;
        $display("FAIL sched_out t=%0t req=%h actual gnt=%h sel=%0d valid=%b owner=%0d expected gnt=%h sel=%0d valid=%b owner=%0d",
                 $time, req, act.gnt, act.sel, act.valid, act.owner,
                 e.gnt, e.sel, e.valid, e.owner);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r_rst, input logic [7:0] r, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r_rst;
      req = r;
    end
  endtask

  initial begin
    logic [7:0] r;
    int         mode;
    rst = 1'b1;
    req = 8'hFF;

    // Reset held two cycles with every requester active, then full rotation.
    drive(1'b1, 8'hFF, 1);
    drive(1'b0, 8'hFF, 8 * MAX_HOLD + 6);

    // Early release and wrap: 7 and 0 compete, 7 drops after two cycles.
    drive(1'b1, 8'h00, 1);
    drive(1'b0, 8'h80, 1);
    drive(1'b0, 8'h81, 2);
    drive(1'b0, 8'h01, 3);
    drive(1'b0, 8'h03, 6);
    drive(1'b0, 8'h00, 2);

    // Sole requester held well past several timeouts.
    drive(1'b0, 8'h20, 12);
    drive(1'b0, 8'h00, 2);

    // Reset mid-tenure, then arbitration restarts from pointer 0.
    drive(1'b0, 8'h08, 3);
    drive(1'b1, 8'h0C, 1);
    drive(1'b0, 8'h0C, 6);
    drive(1'b0, 8'h00, 1);

    // Owner 1 active when 0 arrives: no preemption; 0 then holds while requested.
    drive(1'b0, 8'h02, 2);
    drive(1'b0, 8'h03, 3 * MAX_HOLD);
    drive(1'b0, 8'h01, 2 * MAX_HOLD + 1);
    drive(1'b0, 8'h00, 2);

    // Randomized traffic: request patterns persist for random stretches.
    for (int i = 0; i < 300; i++) begin
      mode = int'($urandom_range(0, 9));
      if (mode < 2)      r = 8'h00;
      else if (mode < 5) r = 8'b1 << $urandom_range(0, 7);
      else               r = 8'($urandom);
      drive(($urandom_range(0, 99) == 0), r, int'($urandom_range(1, 12)));
    end

    drive(1'b0, 8'h00, 2);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
